// File: rtl/coin_change_dispenser.sv
// Greedy 1000/500/100 change payout with per-denomination stock and a one-coin hopper handshake.
// Optional build macro COIN_TIMEOUT_EN adds a hopper ack timeout that raises o_jam.
module coin_change_dispenser #(
    parameter int TOTAL_BITS     = 32,
    parameter int CNT_BITS       = 8,
    parameter int INIT_100       = 20,
    parameter int INIT_500       = 10,
    parameter int INIT_1000      = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_return_req,
    input  logic [TOTAL_BITS-1:0] i_return_amount,
    input  logic [2:0]            i_refill_coin,
    input  logic                  i_coin_ack,
    output logic                  o_busy,
    output logic                  o_coin_valid,
    output logic [2:0]            o_coin_type,
    output logic                  o_done,
    output logic [9:0]            o_num_coins,
    output logic [TOTAL_BITS-1:0] o_shortfall,
    output logic [CNT_BITS-1:0]   o_stock_100,
    output logic [CNT_BITS-1:0]   o_stock_500,
    output logic [CNT_BITS-1:0]   o_stock_1000,
    output logic                  o_jam
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    localparam logic [2:0] C100  = 3'b001;
    localparam logic [2:0] C500  = 3'b010;
    localparam logic [2:0] C1000 = 3'b100;

    localparam logic [TOTAL_BITS-1:0] V100  = TOTAL_BITS'(100);
    localparam logic [TOTAL_BITS-1:0] V500  = TOTAL_BITS'(500);
    localparam logic [TOTAL_BITS-1:0] V1000 = TOTAL_BITS'(1000);

    localparam logic [CNT_BITS-1:0] STOCK_MAX = '1;
    localparam logic [9:0]          NUM_MAX   = '1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state_q, state_d;
    logic [TOTAL_BITS-1:0] remaining_q, remaining_d;
    logic [CNT_BITS-1:0]   stock_100_q, stock_100_d;
    logic [CNT_BITS-1:0]   stock_500_q, stock_500_d;
    logic [CNT_BITS-1:0]   stock_1000_q, stock_1000_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [2:0]            type_q, type_d;
    logic                  done_q, done_d;
    logic [9:0]            num_q, num_d;
    logic [TOTAL_BITS-1:0] short_q, short_d;
    logic [2:0]            take;

`ifdef COIN_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             jam_q, jam_d;
`endif

    function automatic logic [TOTAL_BITS-1:0] coin_value(input logic [2:0] t);
        logic [TOTAL_BITS-1:0] v;
        v = V100;
        if (t[2]) begin
            v = V1000;
        end else if (t[1]) begin
            v = V500;
        end
        return v;
    endfunction

    // Refill saturates first; an ack on the same edge then cancels it out.
    function automatic logic [CNT_BITS-1:0] stock_next(
        input logic [CNT_BITS-1:0] s,
        input logic                inc,
        input logic                dec
    );
        logic [CNT_BITS-1:0] r;
        r = s;
        if (inc && (s != STOCK_MAX)) begin
            r = r + CNT_BITS'(1);
        end
        if (dec) begin
            r = r - CNT_BITS'(1);
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        type_d      = type_q;
        done_d      = 1'b0;
        num_d       = num_q;
        short_d     = short_q;
        take        = 3'b000;
`ifdef COIN_TIMEOUT_EN
        tmr_d       = tmr_q;
        jam_d       = jam_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (i_return_req) begin
                    remaining_d = i_return_amount;
                    num_d       = '0;
                    short_d     = '0;
                    busy_d      = 1'b1;
                    state_d     = S_SELECT;
`ifdef COIN_TIMEOUT_EN
                    jam_d       = 1'b0;
`endif
                end
            end

            S_SELECT: begin
`ifdef COIN_TIMEOUT_EN
                tmr_d = '0;
`endif
                if ((remaining_q >= V1000) && (stock_1000_q != '0)) begin
                    valid_d = 1'b1;
                    type_d  = C1000;
                    state_d = S_WAIT_ACK;
                end else if ((remaining_q >= V500) && (stock_500_q != '0)) begin
                    valid_d = 1'b1;
                    type_d  = C500;
                    state_d = S_WAIT_ACK;
                end else if ((remaining_q >= V100) && (stock_100_q != '0)) begin
                    valid_d = 1'b1;
                    type_d  = C100;
                    state_d = S_WAIT_ACK;
                end else begin
                    short_d = remaining_q;
                    state_d = S_DONE;
                end
            end

            S_WAIT_ACK: begin
                if (i_coin_ack) begin
                    remaining_d = remaining_q - coin_value(type_q);
                    take        = type_q;
                    if (num_q != NUM_MAX) begin
                        num_d = num_q + 10'd1;
                    end
                    valid_d = 1'b0;
                    type_d  = 3'b000;
                    state_d = S_SELECT;
                end
`ifdef COIN_TIMEOUT_EN
                else if (tmr_q == TMR_LAST) begin
                    valid_d = 1'b0;
                    type_d  = 3'b000;
                    short_d = remaining_q;
                    jam_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
`endif
            end

            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        stock_100_d  = stock_next(stock_100_q,  i_refill_coin[0], take[0]);
        stock_500_d  = stock_next(stock_500_q,  i_refill_coin[1], take[1]);
        stock_1000_d = stock_next(stock_1000_q, i_refill_coin[2], take[2]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            stock_100_q  <= CNT_BITS'(INIT_100);
            stock_500_q  <= CNT_BITS'(INIT_500);
            stock_1000_q <= CNT_BITS'(INIT_1000);
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            type_q       <= 3'b000;
            done_q       <= 1'b0;
            num_q        <= '0;
            short_q      <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            stock_100_q  <= stock_100_d;
            stock_500_q  <= stock_500_d;
            stock_1000_q <= stock_1000_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            type_q       <= type_d;
            done_q       <= done_d;
            num_q        <= num_d;
            short_q      <= short_d;
        end
    end

`ifdef COIN_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q <= '0;
            jam_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            jam_q <= jam_d;
        end
    end

    assign o_jam = jam_q;
`else
    assign o_jam = 1'b0;
`endif

    assign o_busy       = busy_q;
    assign o_coin_valid = valid_q;
    assign o_coin_type  = type_q;
    assign o_done       = done_q;
    assign o_num_coins  = num_q;
    assign o_shortfall  = short_q;
    assign o_stock_100  = stock_100_q;
    assign o_stock_500  = stock_500_q;
    assign o_stock_1000 = stock_1000_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser: vector table plus hand-written
// handshake, refill, reset and (with COIN_TIMEOUT_EN) timeout sequences.
module tb_coin_change_dispenser;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ret_req = 1'b0;
    logic [31:0] ret_amt = '0;
    logic [2:0]  refill = '0;
    logic        ack = 1'b0;

    logic        busy_w  [3];
    logic        valid_w [3];
    logic        done_w  [3];
    logic        jam_w   [3];
    logic [2:0]  type_w  [3];
    logic [9:0]  num_w   [3];
    logic [31:0] sf_w    [3];
    logic [7:0]  s100_w  [3];
    logic [7:0]  s500_w  [3];
    logic [7:0]  s1000_w [3];

    int          sel = 0;
    logic        busy, valid, done, jam;
    logic [2:0]  ctype;
    logic [9:0]  num;
    logic [31:0] sf;
    logic [7:0]  s100, s500, s1000;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        busy  = busy_w[sel];
        valid = valid_w[sel];
        done  = done_w[sel];
        jam   = jam_w[sel];
        ctype = type_w[sel];
        num   = num_w[sel];
        sf    = sf_w[sel];
        s100  = s100_w[sel];
        s500  = s500_w[sel];
        s1000 = s1000_w[sel];
    end

    coin_change_dispenser dut0 (
        .clk(clk), .reset_n(reset_n),
        .i_return_req(ret_req), .i_return_amount(ret_amt),
        .i_refill_coin(refill), .i_coin_ack(ack),
        .o_busy(busy_w[0]), .o_coin_valid(valid_w[0]),
        .o_coin_type(type_w[0]), .o_done(done_w[0]),
        .o_num_coins(num_w[0]), .o_shortfall(sf_w[0]),
        .o_stock_100(s100_w[0]), .o_stock_500(s500_w[0]),
        .o_stock_1000(s1000_w[0]), .o_jam(jam_w[0])
    );

    coin_change_dispenser #(.INIT_1000(0)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .i_return_req(ret_req), .i_return_amount(ret_amt),
        .i_refill_coin(refill), .i_coin_ack(ack),
        .o_busy(busy_w[1]), .o_coin_valid(valid_w[1]),
        .o_coin_type(type_w[1]), .o_done(done_w[1]),
        .o_num_coins(num_w[1]), .o_shortfall(sf_w[1]),
        .o_stock_100(s100_w[1]), .o_stock_500(s500_w[1]),
        .o_stock_1000(s1000_w[1]), .o_jam(jam_w[1])
    );

    coin_change_dispenser #(.INIT_100(1), .INIT_500(255)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .i_return_req(ret_req), .i_return_amount(ret_amt),
        .i_refill_coin(refill), .i_coin_ack(ack),
        .o_busy(busy_w[2]), .o_coin_valid(valid_w[2]),
        .o_coin_type(type_w[2]), .o_done(done_w[2]),
        .o_num_coins(num_w[2]), .o_shortfall(sf_w[2]),
        .o_stock_100(s100_w[2]), .o_stock_500(s500_w[2]),
        .o_stock_1000(s1000_w[2]), .o_jam(jam_w[2])
    );

    typedef struct {
        bit          rst;
        int          dut;
        logic [31:0] amt;
        int          n;
        logic [23:0] seq;
        logic [31:0] sf;
        logic [7:0]  s100;
        logic [7:0]  s500;
        logic [7:0]  s1000;
        int          lat;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!valid && k < 50) begin
            tick();
            k++;
        end
        check("wait_valid", valid, 1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 200) begin
            tick();
            k++;
        end
        check("wait_done", done, 1);
    endtask

    // Ack held high throughout; records each presented coin type in 3-bit slots.
    task automatic run_txn(input logic [31:0] amount, output int n,
                           output logic [23:0] seq, output int lat);
        logic prev_valid;
        n = 0;
        seq = '0;
        lat = 0;
        prev_valid = 1'b0;
        ack = 1'b1;
        ret_amt = amount;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        while (!done && lat < 300) begin
            if (valid && !prev_valid) begin
                if (n < 8) seq[3*n +: 3] = ctype;
                n++;
            end
            prev_valid = valid;
            tick();
            lat++;
        end
        ack = 1'b0;
        check("txn_done", done, 1);
    endtask

    initial begin
        int          n;
        logic [23:0] seq;
        int          lat;

        vecs[0] = '{1'b1, 0, 32'd1700, 4,
                    {12'h0, 3'b001, 3'b001, 3'b010, 3'b100},
                    32'd0, 8'd18, 8'd9, 8'd9, 10};
        vecs[1] = '{1'b0, 0, 32'd250, 2, {18'h0, 3'b001, 3'b001},
                    32'd50, 8'd16, 8'd9, 8'd9, 6};
        vecs[2] = '{1'b0, 0, 32'd0, 0, 24'h0,
                    32'd0, 8'd16, 8'd9, 8'd9, 2};
        vecs[3] = '{1'b0, 0, 32'd3099, 3,
                    {15'h0, 3'b100, 3'b100, 3'b100},
                    32'd99, 8'd16, 8'd9, 8'd6, 8};
        vecs[4] = '{1'b1, 1, 32'd2300, 7,
                    {3'b000, 3'b001, 3'b001, 3'b001,
                     3'b010, 3'b010, 3'b010, 3'b010},
                    32'd0, 8'd17, 8'd6, 8'd0, 16};
        vecs[5] = '{1'b1, 2, 32'd300, 1, {21'h0, 3'b001},
                    32'd200, 8'd0, 8'd255, 8'd10, 4};
        vecs[6] = '{1'b0, 2, 32'd600, 1, {21'h0, 3'b010},
                    32'd100, 8'd0, 8'd254, 8'd10, 4};

        // Reset defaults
        sel = 0;
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_type", ctype, 0);
        check("rst_done", done, 0);
        check("rst_num", num, 0);
        check("rst_shortfall", sf, 0);
        check("rst_jam", jam, 0);
        check("rst_s100", s100, 20);
        check("rst_s500", s500, 10);
        check("rst_s1000", s1000, 10);

        foreach (vecs[i]) begin
            sel = vecs[i].dut;
            if (vecs[i].rst) do_reset();
            run_txn(vecs[i].amt, n, seq, lat);
            check($sformatf("v%0d_seq", i), seq, vecs[i].seq);
            check($sformatf("v%0d_seen", i), n, vecs[i].n);
            check($sformatf("v%0d_num", i), num, vecs[i].n);
            check($sformatf("v%0d_short", i), sf, vecs[i].sf);
            check($sformatf("v%0d_s100", i), s100, vecs[i].s100);
            check($sformatf("v%0d_s500", i), s500, vecs[i].s500);
            check($sformatf("v%0d_s1000", i), s1000, vecs[i].s1000);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy", i), busy, 0);
            tick();
            check($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // Delayed ack with an ignored request while busy
        sel = 0;
        do_reset();
        ret_amt = 32'd100;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", valid, 1);
            check("hold_type", ctype, 3'b001);
            check("hold_s100", s100, 20);
            ret_req = (i == 0);
            ret_amt = 32'd1000;
            tick();
        end
        ret_req = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_s100", s100, 19);
        check("ack_valid", valid, 0);
        wait_done();
        check("busyreq_num", num, 1);
        check("busyreq_short", sf, 0);
        check("busyreq_s1000", s1000, 10);

        // Refill on the same edge as a 100-coin ack
        ret_amt = 32'd100;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        wait_valid();
        ack = 1'b1;
        refill = 3'b001;
        tick();
        ack = 1'b0;
        refill = 3'b000;
        check("refill_ack_s100", s100, 19);
        wait_done();
        check("refill_ack_num", num, 1);
        refill = 3'b100;
        tick();
        refill = 3'b000;
        check("refill_idle_s1000", s1000, 11);

        // Asynchronous reset in the middle of WAIT_ACK
        ret_amt = 32'd1000;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        wait_valid();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", valid, 0);
        check("arst_busy", busy, 0);
        check("arst_type", ctype, 0);
        check("arst_s100", s100, 20);
        check("arst_s1000", s1000, 10);
        #1;
        reset_n = 1'b1;
        tick();

        // Refill at saturation
        sel = 2;
        do_reset();
        refill = 3'b010;
        tick();
        check("sat_s500", s500, 255);
        refill = 3'b001;
        tick();
        refill = 3'b000;
        check("sat_s500_hold", s500, 255);
        check("refill_s100", s100, 2);

`ifdef COIN_TIMEOUT_EN
        begin
            int vc;
            sel = 0;
            do_reset();
            ret_amt = 32'd500;
            ret_req = 1'b1;
            tick();
            ret_req = 1'b0;
            wait_valid();
            vc = 0;
            while (valid && vc < 40) begin
                vc++;
                tick();
            end
            check("to_valid_cycles", vc, 16);
            wait_done();
            check("to_jam", jam, 1);
            check("to_short", sf, 500);
            check("to_num", num, 0);
            check("to_s500", s500, 10);
            tick();
            check("to_jam_sticky", jam, 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
